// File: rtl/sc_reggeneral_multilane.sv
// Multi-lane general-purpose register: synchronous clear, full parallel load,
// single-lane load, logical shifts, rotates, increment and decrement.
// Status flags report the last bit shifted out, the last carry/borrow,
// a zero indication and a one-cycle "value changed" pulse.
module sc_reggeneral_multilane #(
    parameter int LANE_WIDTH    = 4,
    parameter int LANES         = 2,
    parameter int LANESEL_WIDTH = 1
) (
    input  logic                          SC_RegMULTI_CLOCK_50,
    input  logic                          SC_RegMULTI_RESET_InHigh,
    input  logic                          SC_RegMULTI_clear_InLow,
    input  logic                          SC_RegMULTI_load_InLow,
    input  logic                          SC_RegMULTI_laneload_InLow,
    input  logic [LANESEL_WIDTH-1:0]      SC_RegMULTI_lanesel_InBUS,
    input  logic [2:0]                    SC_RegMULTI_mode_InBUS,
    input  logic                          SC_RegMULTI_serial_In,
    input  logic [LANE_WIDTH*LANES-1:0]   SC_RegMULTI_data_InBUS,
    input  logic [LANE_WIDTH-1:0]         SC_RegMULTI_lane_InBUS,
    output logic [LANE_WIDTH*LANES-1:0]   SC_RegMULTI_data_OutBUS,
    output logic                          SC_RegMULTI_serial_Out,
    output logic                          SC_RegMULTI_carry_Out,
    output logic                          SC_RegMULTI_zero_Out,
    output logic                          SC_RegMULTI_changed_Out
);

    localparam int DW = LANE_WIDTH * LANES;

    localparam logic [2:0] MODE_HOLD0 = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ROL   = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_INC   = 3'b101;
    localparam logic [2:0] MODE_DEC   = 3'b110;
    localparam logic [2:0] MODE_HOLD7 = 3'b111;

    logic [DW-1:0] reg_q, reg_d;
    logic          serial_q, serial_d;
    logic          carry_q, carry_d;
    logic          changed_q, changed_d;

    // Arithmetic results carry one extra bit so the wrap shows up as bit DW.
    logic [DW:0]   inc_full;
    logic [DW:0]   dec_full;
    logic [31:0]   lanesel_ext;

    assign inc_full    = {1'b0, reg_q} + (DW+1)'(1);
    assign dec_full    = {1'b0, reg_q} - (DW+1)'(1);
    assign lanesel_ext = 32'(SC_RegMULTI_lanesel_InBUS);

    // Next-state selection in priority order: clear, full load, lane load, mode.
    always_comb begin
        reg_d    = reg_q;
        serial_d = serial_q;
        carry_d  = carry_q;
        if (!SC_RegMULTI_clear_InLow) begin
            reg_d    = '0;
            serial_d = 1'b0;
            carry_d  = 1'b0;
        end else if (!SC_RegMULTI_load_InLow) begin
            reg_d = SC_RegMULTI_data_InBUS;
        end else if (!SC_RegMULTI_laneload_InLow) begin
            // An out-of-range lane index matches no lane, so the register holds.
            for (int l = 0; l < LANES; l++) begin
                if (lanesel_ext == 32'(l)) begin
                    reg_d[l*LANE_WIDTH +: LANE_WIDTH] = SC_RegMULTI_lane_InBUS;
                end
            end
        end else begin
            case (SC_RegMULTI_mode_InBUS)
                MODE_SHL: begin
                    reg_d    = {reg_q[DW-2:0], SC_RegMULTI_serial_In};
                    serial_d = reg_q[DW-1];
                end
                MODE_SHR: begin
                    reg_d    = {SC_RegMULTI_serial_In, reg_q[DW-1:1]};
                    serial_d = reg_q[0];
                end
                MODE_ROL: begin
                    reg_d    = {reg_q[DW-2:0], reg_q[DW-1]};
                    serial_d = reg_q[DW-1];
                end
                MODE_ROR: begin
                    reg_d    = {reg_q[0], reg_q[DW-1:1]};
                    serial_d = reg_q[0];
                end
                MODE_INC: begin
                    reg_d   = inc_full[DW-1:0];
                    carry_d = inc_full[DW];
                end
                MODE_DEC: begin
                    reg_d   = dec_full[DW-1:0];
                    carry_d = dec_full[DW];
                end
                MODE_HOLD0, MODE_HOLD7: begin
                    reg_d = reg_q;
                end
                default: begin
                    reg_d = reg_q;
                end
            endcase
        end
        changed_d = (reg_d != reg_q);
    end

    // State register; reset clears everything without waiting for a clock.
    always_ff @(posedge SC_RegMULTI_CLOCK_50 or posedge SC_RegMULTI_RESET_InHigh) begin
        if (SC_RegMULTI_RESET_InHigh) begin
            reg_q     <= '0;
            serial_q  <= 1'b0;
            carry_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            reg_q     <= reg_d;
            serial_q  <= serial_d;
            carry_q   <= carry_d;
            changed_q <= changed_d;
        end
    end

    assign SC_RegMULTI_data_OutBUS = reg_q;
    assign SC_RegMULTI_serial_Out  = serial_q;
    assign SC_RegMULTI_carry_Out   = carry_q;
    assign SC_RegMULTI_changed_Out = changed_q;
    assign SC_RegMULTI_zero_Out    = (reg_q == '0);

endmodule

// File: tb/tb_sc_reggeneral_multilane.sv
// Directed bench for sc_reggeneral_multilane with LANE_WIDTH=4, LANES=2.
module tb_sc_reggeneral_multilane;

    logic       clk;
    logic       rst;
    logic       clear_n;
    logic       load_n;
    logic       laneload_n;
    logic [0:0] lanesel;
    logic [2:0] mode;
    logic       serial_in;
    logic [7:0] data_in;
    logic [3:0] lane_in;
    logic [7:0] data_out;
    logic       serial_out;
    logic       carry_out;
    logic       zero_out;
    logic       changed_out;

    int checks;
    int failures;

    sc_reggeneral_multilane #(
        .LANE_WIDTH   (4),
        .LANES        (2),
        .LANESEL_WIDTH(1)
    ) dut (
        .SC_RegMULTI_CLOCK_50      (clk),
        .SC_RegMULTI_RESET_InHigh  (rst),
        .SC_RegMULTI_clear_InLow   (clear_n),
        .SC_RegMULTI_load_InLow    (load_n),
        .SC_RegMULTI_laneload_InLow(laneload_n),
        .SC_RegMULTI_lanesel_InBUS (lanesel),
        .SC_RegMULTI_mode_InBUS    (mode),
        .SC_RegMULTI_serial_In     (serial_in),
        .SC_RegMULTI_data_InBUS    (data_in),
        .SC_RegMULTI_lane_InBUS    (lane_in),
        .SC_RegMULTI_data_OutBUS   (data_out),
        .SC_RegMULTI_serial_Out    (serial_out),
        .SC_RegMULTI_carry_Out     (carry_out),
        .SC_RegMULTI_zero_Out      (zero_out),
        .SC_RegMULTI_changed_Out   (changed_out)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear_n    = 1'b1;
        load_n     = 1'b1;
        laneload_n = 1'b1;
        lanesel    = 1'b0;
        mode       = 3'b000;
        serial_in  = 1'b0;
        data_in    = 8'h00;
        lane_in    = 4'h0;
    endtask

    task automatic do_load(input logic [7:0] v);
        idle();
        load_n  = 1'b0;
        data_in = v;
        tick();
        idle();
    endtask

    task automatic do_mode(input logic [2:0] m, input logic si);
        idle();
        mode      = m;
        serial_in = si;
        tick();
        idle();
    endtask

    task automatic do_lane(input logic [0:0] sel, input logic [3:0] v);
        idle();
        laneload_n = 1'b0;
        lanesel    = sel;
        lane_in    = v;
        tick();
        idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        rst = 1'b1;
        #2;
        // Reset values before any clock edge
        chk("rst_data",    32'(data_out),    32'h00);
        chk("rst_serial",  32'(serial_out),  32'h0);
        chk("rst_carry",   32'(carry_out),   32'h0);
        chk("rst_changed", 32'(changed_out), 32'h0);
        chk("rst_zero",    32'(zero_out),    32'h1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_data", 32'(data_out), 32'h00);

        // Full load
        do_load(8'hA5);
        chk("load_data",    32'(data_out),    32'hA5);
        chk("load_changed", 32'(changed_out), 32'h1);
        chk("load_zero",    32'(zero_out),    32'h0);
        tick();
        chk("hold_changed", 32'(changed_out), 32'h0);
        chk("hold_data",    32'(data_out),    32'hA5);

        // Lane loads
        do_lane(1'b1, 4'h3);
        chk("lane1_data",    32'(data_out),    32'h35);
        chk("lane1_changed", 32'(changed_out), 32'h1);
        do_lane(1'b1, 4'h3);
        chk("lane1_same_data",    32'(data_out),    32'h35);
        chk("lane1_same_changed", 32'(changed_out), 32'h0);
        do_lane(1'b0, 4'hC);
        chk("lane0_data", 32'(data_out), 32'h3C);

        // Shifts and rotates
        do_load(8'h81);
        do_mode(3'b001, 1'b0);
        chk("shl_data",   32'(data_out),   32'h02);
        chk("shl_serial", 32'(serial_out), 32'h1);
        chk("shl_carry",  32'(carry_out),  32'h0);
        do_mode(3'b010, 1'b1);
        chk("shr_data",   32'(data_out),   32'h81);
        chk("shr_serial", 32'(serial_out), 32'h0);
        do_load(8'h01);
        do_mode(3'b100, 1'b0);
        chk("ror_data",   32'(data_out),   32'h80);
        chk("ror_serial", 32'(serial_out), 32'h1);
        do_mode(3'b011, 1'b0);
        chk("rol_data",   32'(data_out),   32'h01);
        chk("rol_serial", 32'(serial_out), 32'h1);

        // Arithmetic wrap and flag retention
        do_load(8'hFF);
        do_mode(3'b101, 1'b0);
        chk("inc_wrap_data",   32'(data_out),   32'h00);
        chk("inc_wrap_carry",  32'(carry_out),  32'h1);
        chk("inc_wrap_zero",   32'(zero_out),   32'h1);
        chk("inc_keep_serial", 32'(serial_out), 32'h1);
        do_mode(3'b110, 1'b0);
        chk("dec_wrap_data",  32'(data_out),  32'hFF);
        chk("dec_wrap_carry", 32'(carry_out), 32'h1);
        do_mode(3'b000, 1'b0);
        chk("hold0_data",    32'(data_out),    32'hFF);
        chk("hold0_carry",   32'(carry_out),   32'h1);
        chk("hold0_changed", 32'(changed_out), 32'h0);
        do_load(8'h10);
        chk("load_keep_carry", 32'(carry_out), 32'h1);
        do_mode(3'b101, 1'b0);
        chk("inc_data",  32'(data_out),  32'h11);
        chk("inc_carry", 32'(carry_out), 32'h0);
        do_mode(3'b111, 1'b1);
        chk("hold7_data", 32'(data_out), 32'h11);
        do_mode(3'b110, 1'b0);
        chk("dec_data",  32'(data_out),  32'h10);
        chk("dec_carry", 32'(carry_out), 32'h0);

        // Clear beats load and mode
        idle();
        clear_n = 1'b0;
        load_n  = 1'b0;
        data_in = 8'h55;
        mode    = 3'b101;
        tick();
        idle();
        chk("clear_data",    32'(data_out),    32'h00);
        chk("clear_serial",  32'(serial_out),  32'h0);
        chk("clear_changed", 32'(changed_out), 32'h1);

        // Load beats lane load and mode
        idle();
        load_n     = 1'b0;
        data_in    = 8'hC3;
        laneload_n = 1'b0;
        lanesel    = 1'b0;
        lane_in    = 4'hF;
        mode       = 3'b001;
        tick();
        idle();
        chk("load_over_lane", 32'(data_out), 32'hC3);
        chk("load_over_lane_serial", 32'(serial_out), 32'h0);

        // Reset in the middle of an increment run
        do_load(8'hFD);
        do_mode(3'b101, 1'b0);
        chk("pre_rst_inc", 32'(data_out), 32'hFE);
        mode = 3'b101;
        tick();
        chk("pre_rst_inc2", 32'(data_out), 32'hFF);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_data",    32'(data_out),    32'h00);
        chk("mid_rst_zero",    32'(zero_out),    32'h1);
        chk("mid_rst_changed", 32'(changed_out), 32'h0);
        idle();
        tick();
        rst = 1'b0;
        tick();
        chk("after_rst_changed", 32'(changed_out), 32'h0);
        chk("after_rst_data",    32'(data_out),    32'h00);
        do_mode(3'b101, 1'b0);
        chk("after_rst_inc", 32'(data_out), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
